// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer memory arbiter: issue-tag
// encoding, frame-buffer geometry and a small tag helper.
package fb_pkg;

  // Identifies which client owns the RAM operation in each pipeline stage.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_VGA    = 2'd1,
    TAG_CPU_RD = 2'd2,
    TAG_CPU_WR = 2'd3
  } fb_tag_e;

  // Frame buffer occupies the top 4K words of the shared address space.
  localparam logic [15:0] FRAME_BUFFER_START = 16'hF000;

  // Words fetched per text row by the VGA address generator.
  localparam int SCREEN_WIDTH = 80;

  // True when a tag belongs to the CPU load/store port.
  function automatic logic tag_is_cpu(input fb_tag_e tag);
    logic is_cpu;
    case (tag)
      TAG_CPU_RD: is_cpu = 1'b1;
      TAG_CPU_WR: is_cpu = 1'b1;
      default:    is_cpu = 1'b0;
    endcase
    return is_cpu;
  endfunction

endpackage

// File: rtl/fb_arb_pipe.sv
// Two-stage issue pipeline for the shared RAM. Stage 1 registers the
// RAM command together with its owner tag; stage 2 is the tag aligned
// with the RAM read-data cycle, so the top can route mem_rdata back to
// the right client without the tags ever crossing.
module fb_arb_pipe
  import fb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  fb_tag_e           issue_tag_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic [DATA_W-1:0] issue_wdata_i,
  output fb_tag_e           tag1_o,
  output fb_tag_e           tag2_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o
);

  fb_tag_e           tag1_q, tag1_d;
  fb_tag_e           tag2_q, tag2_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Next-state for the RAM command registers and the tag shift chain.
  always_comb begin
    tag1_d      = issue_tag_i;
    tag2_d      = tag1_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (issue_tag_i)
      TAG_VGA: begin
        mem_en_d   = 1'b1;
        mem_addr_d = issue_addr_i;
      end
      TAG_CPU_RD: begin
        mem_en_d   = 1'b1;
        mem_addr_d = issue_addr_i;
      end
      TAG_CPU_WR: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = issue_addr_i;
        mem_wdata_d = issue_wdata_i;
      end
      default: begin
        // Idle slot: RAM disabled, address/data simply hold.
        mem_en_d = 1'b0;
      end
    endcase
  end

  // Pipeline registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign tag1_o      = tag1_q;
  assign tag2_o      = tag2_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: rtl/fb_mem_arbiter.sv
// Arbitrates one synchronous single-port RAM between the VGA fetch port
// (strict priority, fixed 2-cycle latency) and the CPU load/store port
// (req/ack handshake, one op in flight). A saturating counter tracks how
// long a pending CPU request keeps losing to VGA and raises a sticky
// starvation flag; VGA priority itself is never overridden.
module fb_mem_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starved,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  fb_tag_e           issue_tag_s;
  logic [ADDR_W-1:0] issue_addr_s;
  logic [DATA_W-1:0] issue_wdata_s;
  logic              cpu_grant_s;
  logic              cpu_ack_s;
  logic              vga_hit_s;
  logic              cpu_rd_hit_s;
  fb_tag_e           tag1_s;
  fb_tag_e           tag2_s;

  logic              cpu_inflight_q, cpu_inflight_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              cpu_starved_q, cpu_starved_d;

  // Issue selection: VGA first, then a CPU op if none is outstanding.
  always_comb begin
    issue_tag_s   = TAG_NONE;
    issue_addr_s  = '0;
    issue_wdata_s = '0;
    if (vga_req) begin
      issue_tag_s  = TAG_VGA;
      issue_addr_s = vga_addr;
    end else if (cpu_req && !cpu_inflight_q) begin
      issue_tag_s   = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      issue_addr_s  = cpu_addr;
      issue_wdata_s = cpu_wdata;
    end else begin
      issue_tag_s = TAG_NONE;
    end
  end

  assign cpu_grant_s = tag_is_cpu(issue_tag_s);

  // Writes complete as soon as the RAM command is registered; reads
  // complete when their data comes back out of the RAM.
  assign cpu_ack_s    = (tag1_s == TAG_CPU_WR) | (tag2_s == TAG_CPU_RD);
  assign vga_hit_s    = (tag2_s == TAG_VGA);
  assign cpu_rd_hit_s = (tag2_s == TAG_CPU_RD);

  // In-flight flag plus the starvation counter and its sticky flag.
  always_comb begin
    cpu_inflight_d = cpu_inflight_q;
    wait_cnt_d     = wait_cnt_q;
    cpu_starved_d  = cpu_starved_q;

    // Ack cycle ends the op; a grant can never coincide with an ack
    // because grants are blocked while an op is in flight.
    if (cpu_grant_s) begin
      cpu_inflight_d = 1'b1;
    end else if (cpu_ack_s) begin
      cpu_inflight_d = 1'b0;
    end else begin
      cpu_inflight_d = cpu_inflight_q;
    end

    // Count only cycles where the CPU was eligible and VGA took the slot.
    if (!cpu_req || cpu_grant_s) begin
      wait_cnt_d = '0;
    end else if (vga_req && !cpu_inflight_q && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1'b1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    if (wait_cnt_d == CNT_MAX) begin
      cpu_starved_d = 1'b1;
    end else begin
      cpu_starved_d = cpu_starved_q;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_inflight_q <= 1'b0;
      wait_cnt_q     <= '0;
      cpu_starved_q  <= 1'b0;
    end else begin
      cpu_inflight_q <= cpu_inflight_d;
      wait_cnt_q     <= wait_cnt_d;
      cpu_starved_q  <= cpu_starved_d;
    end
  end

  fb_arb_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk           (clk),
    .reset         (reset),
    .issue_tag_i   (issue_tag_s),
    .issue_addr_i  (issue_addr_s),
    .issue_wdata_i (issue_wdata_s),
    .tag1_o        (tag1_s),
    .tag2_o        (tag2_s),
    .mem_en_o      (mem_en),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata)
  );

  // Read data is steered to its owner and forced to zero elsewhere so
  // neither data port ever shows an unknown value after reset.
  assign vga_valid   = vga_hit_s;
  assign vga_rdata   = vga_hit_s ? mem_rdata : '0;
  assign cpu_ack     = cpu_ack_s;
  assign cpu_rdata   = cpu_rd_hit_s ? mem_rdata : '0;
  assign cpu_starved = cpu_starved_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Self-checking bench for fb_mem_arbiter: directed vector table, hand
// sequences for starvation and reset mid-op, then randomized traffic
// checked against a cycle-indexed event model of the arbitration rules.
module tb_fb_mem_arbiter;
  import fb_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LIM   = 4;
  localparam int NRAND = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_valid;
  logic [DW-1:0] vga_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_starved;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  fb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_starved(cpu_starved),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Power-on contents of the RAM, shared by the RAM model and the reference model.
  function automatic logic [15:0] init_word(input logic [15:0] a);
    case (a)
      16'hF000: return 16'h4142;
      16'hF001: return 16'h4344;
      16'h0020: return 16'h5A5A;
      16'h0040: return 16'h7777;
      16'h0050: return 16'h0BAD;
      default:  return a ^ 16'hA5C3;
    endcase
  endfunction

  // Synchronous single-port RAM model.
  logic [15:0] ram    [0:65535];
  bit          ram_wr [0:65535];
  logic [15:0] ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        ram_q <= ram_wr[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
      end
    end
  end
  assign mem_rdata = ram_q;

  // Reference memory image, updated in issue order by the model.
  logic [15:0] sh    [0:65535];
  bit          sh_wr [0:65535];
  function automatic logic [15:0] sh_read(input logic [15:0] a);
    return sh_wr[a] ? sh[a] : init_word(a);
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic vr, input logic [15:0] va, input logic cr,
                       input logic cw, input logic [15:0] ca, input logic [15:0] cd);
    vga_req   = vr;
    vga_addr  = va;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vga_valid"},   vga_valid,   32'd0);
    check({tag, "_vga_rdata"},   vga_rdata,   32'd0);
    check({tag, "_cpu_ack"},     cpu_ack,     32'd0);
    check({tag, "_cpu_rdata"},   cpu_rdata,   32'd0);
    check({tag, "_cpu_starved"}, cpu_starved, 32'd0);
    check({tag, "_mem_en"},      mem_en,      32'd0);
    check({tag, "_mem_we"},      mem_we,      32'd0);
    check({tag, "_mem_addr"},    mem_addr,    32'd0);
    check({tag, "_mem_wdata"},   mem_wdata,   32'd0);
  endtask

  typedef struct {
    logic        vr;  logic [15:0] va;
    logic        cr;  logic cw; logic [15:0] ca; logic [15:0] cd;
    logic        e_vv; logic [15:0] e_vd;
    logic        e_ack; logic [15:0] e_cd;
    logic        e_en; logic e_we; logic [15:0] e_ma;
  } vec_t;

  function automatic vec_t mk(input logic vr, input logic [15:0] va, input logic cr,
                              input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                              input logic e_vv, input logic [15:0] e_vd,
                              input logic e_ack, input logic [15:0] e_cd,
                              input logic e_en, input logic e_we, input logic [15:0] e_ma);
    vec_t v;
    v.vr = vr; v.va = va; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.e_vv = e_vv; v.e_vd = e_vd; v.e_ack = e_ack; v.e_cd = e_cd;
    v.e_en = e_en; v.e_we = e_we; v.e_ma = e_ma;
    return v;
  endfunction

  vec_t tbl [16];

  // Random-phase expectations indexed by sample cycle.
  bit          x_vv  [0:NRAND+2];
  logic [15:0] x_vd  [0:NRAND+2];
  bit          x_ack [0:NRAND+2];
  bit          x_rd  [0:NRAND+2];
  logic [15:0] x_cd  [0:NRAND+2];

  initial begin
    logic [15:0] fb0;
    logic [15:0] fb1;
    int          busy_until;
    int          wcnt;
    bit          starved;
    int          last_v;
    int          burst;
    bit          v;
    bit          granted;

    fb0 = FRAME_BUFFER_START;
    fb1 = FRAME_BUFFER_START + 16'd1;

    // ---------------- reset state ----------------
    reset = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;

    // ---------------- directed table ----------------
    //            vr    va     cr    cw    ca        cd        vv    vd        ack   cd        en    we    ma
    tbl[0]  = mk(1'b1, fb0,   1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, fb0);
    tbl[1]  = mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h4142, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tbl[2]  = mk(1'b1, fb1,   1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, fb1);
    tbl[3]  = mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h4344, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tbl[4]  = mk(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0010);
    tbl[5]  = mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tbl[6]  = mk(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010);
    tbl[7]  = mk(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
    tbl[8]  = mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tbl[9]  = mk(1'b1, fb0,   1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, fb0);
    tbl[10] = mk(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h4142, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020);
    tbl[11] = mk(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0000);
    tbl[12] = mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tbl[13] = mk(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020);
    tbl[14] = mk(1'b1, fb1,   1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h5A5A, 1'b1, 1'b0, fb1);
    tbl[15] = mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h4344, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

    for (int r = 0; r < 16; r++) begin
      drive(tbl[r].vr, tbl[r].va, tbl[r].cr, tbl[r].cw, tbl[r].ca, tbl[r].cd);
      step();
      check($sformatf("tbl%0d_vga_valid", r), vga_valid, tbl[r].e_vv);
      check($sformatf("tbl%0d_cpu_ack", r), cpu_ack, tbl[r].e_ack);
      check($sformatf("tbl%0d_mem_en", r), mem_en, tbl[r].e_en);
      check($sformatf("tbl%0d_starved", r), cpu_starved, 32'd0);
      if (tbl[r].e_en) begin
        check($sformatf("tbl%0d_mem_we", r), mem_we, tbl[r].e_we);
        check($sformatf("tbl%0d_mem_addr", r), mem_addr, tbl[r].e_ma);
      end
      if (tbl[r].e_we) begin
        check($sformatf("tbl%0d_mem_wdata", r), mem_wdata, tbl[r].cd);
      end
      if (tbl[r].e_vv) begin
        check($sformatf("tbl%0d_vga_rdata", r), vga_rdata, tbl[r].e_vd);
      end
      if (tbl[r].e_ack && !tbl[r].cw) begin
        check($sformatf("tbl%0d_cpu_rdata", r), cpu_rdata, tbl[r].e_cd);
      end
    end

    // ---------------- starvation ----------------
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, fb0, 1'b1, 1'b0, 16'h0040, 16'h0000);
      step();
      check($sformatf("starve%0d_vga_wins", i), mem_addr, fb0);
      check($sformatf("starve%0d_flag", i), cpu_starved, (i >= LIM) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);
    step();
    check("starve_grant_en", mem_en, 32'd1);
    check("starve_grant_addr", mem_addr, 32'h0040);
    step();
    check("starve_ack", cpu_ack, 32'd1);
    check("starve_rdata", cpu_rdata, 32'h7777);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    check("starve_sticky", cpu_starved, 32'd1);

    // ---------------- reset mid-op ----------------
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0050, 16'h0000);
    step();
    check("rst_grant_addr", mem_addr, 32'h0050);
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    step();
    check("rst_no_ack", cpu_ack, 32'd0);
    check("rst_no_valid", vga_valid, 32'd0);
    reset = 1'b0;
    step();
    check("rst_reissue_en", mem_en, 32'd1);
    check("rst_reissue_addr", mem_addr, 32'h0050);
    check("rst_reissue_early_ack", cpu_ack, 32'd0);
    step();
    check("rst_reissue_ack", cpu_ack, 32'd1);
    check("rst_reissue_rdata", cpu_rdata, 32'h0BAD);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();

    // ---------------- randomized traffic vs reference model ----------------
    reset = 1'b1;
    step();
    reset = 1'b0;
    sh[16'h0010]    = 16'hBEEF;
    sh_wr[16'h0010] = 1'b1;
    busy_until = -10;
    wcnt       = 0;
    starved    = 1'b0;
    last_v     = -10;
    burst      = 0;

    for (int k = 0; k < NRAND; k++) begin
      // VGA: normally at most one req per 2 cycles, with occasional bursts.
      if (burst == 0 && $urandom_range(0, 99) == 0) begin
        burst = $urandom_range(3, 7);
      end
      if (burst > 0) begin
        v = 1'b1;
        burst--;
      end else begin
        v = ($urandom_range(0, 9) < 4) && (k != last_v + 1);
      end
      if (v) last_v = k;
      vga_req  = v;
      vga_addr = fb0 + 16'($urandom_range(0, SCREEN_WIDTH - 1));

      // CPU: start a new request when idle; hold it stable until acked.
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = ($urandom_range(0, 3) == 0) ? fb0 + 16'($urandom_range(0, 7))
                                                : 16'($urandom_range(0, 31));
        cpu_wdata = 16'($urandom);
      end

      // Reference: what happens at edge k, expressed as future events.
      granted = 1'b0;
      if (v) begin
        x_vv[k+1] = 1'b1;
        x_vd[k+1] = sh_read(vga_addr);
      end else if (cpu_req && (k > busy_until)) begin
        granted = 1'b1;
        if (cpu_we) begin
          sh[cpu_addr]    = cpu_wdata;
          sh_wr[cpu_addr] = 1'b1;
          x_ack[k]        = 1'b1;
          busy_until      = k + 1;
        end else begin
          x_ack[k+1] = 1'b1;
          x_rd[k+1]  = 1'b1;
          x_cd[k+1]  = sh_read(cpu_addr);
          busy_until = k + 2;
        end
      end
      if (!cpu_req || granted) begin
        wcnt = 0;
      end else if (v && (k > busy_until)) begin
        wcnt = (wcnt < LIM) ? wcnt + 1 : LIM;
      end
      if (wcnt == LIM) starved = 1'b1;

      step();

      check("rnd_vga_valid", vga_valid, x_vv[k]);
      check("rnd_cpu_ack", cpu_ack, x_ack[k]);
      check("rnd_starved", cpu_starved, starved);
      if (x_vv[k]) check("rnd_vga_rdata", vga_rdata, x_vd[k]);
      if (x_rd[k]) check("rnd_cpu_rdata", cpu_rdata, x_cd[k]);
      if (x_ack[k]) cpu_req = 1'b0;
    end

    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
